// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern generator.
package bist_pkg;

  localparam int unsigned NUM_BITS_DEF = 54;
  localparam int unsigned CNT_BITS_DEF = 16;

  // XNOR feedback taps of the 54-bit maximal-length LFSR
  localparam int unsigned TAP_0 = 53;
  localparam int unsigned TAP_1 = 52;
  localparam int unsigned TAP_2 = 17;
  localparam int unsigned TAP_3 = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/prpg_lfsr.sv
// Pattern register: seed load with lockup-state substitution and one XNOR-LFSR step per request.
module prpg_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [NUM_BITS-1:0] seed,
  output logic [NUM_BITS-1:0] data
);

  logic                fb_c;
  logic [NUM_BITS-1:0] seed_c;

  assign fb_c = ((data[TAP_0] ~^ data[TAP_1]) ~^ data[TAP_2]) ~^ data[TAP_3];

  // All-ones is the XNOR lockup state; it would never leave itself
  assign seed_c = (&seed) ? '0 : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= seed_c;
    end else if (step) begin
      data <= {data[NUM_BITS-2:0], fb_c};
    end
  end

endmodule

// File: rtl/bist_prpg.sv
// BIST pseudo-random pattern generator: test sequencing, pattern counting and valid/ready handshake.
module bist_prpg
  import bist_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BITS_DEF,
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NUM_BITS-1:0] i_seed,
  input  logic [CNT_BITS-1:0] i_num_patterns,
  input  logic                i_ready,
  output logic                o_vld,
  output logic [NUM_BITS-1:0] o_data,
  output logic                o_first,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_BITS-1:0] o_pattern_cnt
);

  state_t              state;
  logic [CNT_BITS-1:0] num;
  logic                load_c;
  logic                step_c;

  assign load_c = (state == IDLE) && i_start;
  // Abort wins over a coincident transfer, so the pattern is not consumed
  assign step_c = (state == RUN) && o_vld && i_ready && !i_abort;

  prpg_lfsr #(
    .NUM_BITS(NUM_BITS)
  ) u_lfsr (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .load (load_c),
    .step (step_c),
    .seed (i_seed),
    .data (o_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      num           <= '0;
      o_vld         <= 1'b0;
      o_first       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_pattern_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            num           <= i_num_patterns;
            o_pattern_cnt <= '0;
            o_busy        <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (num == '0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_vld   <= 1'b1;
            o_first <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (i_abort) begin
            o_vld   <= 1'b0;
            o_first <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else if (step_c) begin
            o_pattern_cnt <= o_pattern_cnt + CNT_BITS'(1);
            o_first       <= 1'b0;
            if (o_pattern_cnt == num - CNT_BITS'(1)) begin
              o_vld  <= 1'b0;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_prpg.sv
// Self-checking bench for bist_prpg: directed table, handshake corner sequences and randomized tests vs. a reference model.
module tb_bist_prpg;

  localparam int unsigned NB = 54;
  localparam int unsigned CB = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic          i_abort;
  logic [NB-1:0] i_seed;
  logic [CB-1:0] i_num_patterns;
  logic          i_ready;
  logic          o_vld;
  logic [NB-1:0] o_data;
  logic          o_first;
  logic          o_busy;
  logic          o_done;
  logic [CB-1:0] o_pattern_cnt;

  int n_pass;
  int n_total;

  bist_prpg dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_seed        (i_seed),
    .i_num_patterns(i_num_patterns),
    .i_ready       (i_ready),
    .o_vld         (o_vld),
    .o_data        (o_data),
    .o_first       (o_first),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pattern_cnt (o_pattern_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [NB-1:0] seed;
    logic [CB-1:0] num;
    logic [NB-1:0] exp_first;
    logic [NB-1:0] exp_last;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Next pattern: shift left, new LSB is 1 when the tap bits hold an even number of ones
  function automatic logic [NB-1:0] ref_next(input logic [NB-1:0] p);
    int ones;
    ones = int'(p[53]) + int'(p[52]) + int'(p[17]) + int'(p[16]);
    return {p[52:0], (ones % 2 == 0)};
  endfunction

  function automatic logic [NB-1:0] ref_seed(input logic [NB-1:0] s);
    return (s == {NB{1'b1}}) ? '0 : s;
  endfunction

  task automatic run_test(input logic [NB-1:0] seed, input logic [CB-1:0] num, input int ready_pct,
                          output logic [NB-1:0] first_pat, output logic [NB-1:0] last_pat,
                          output int ntx);
    logic [NB-1:0] q[$];
    logic [NB-1:0] p;
    int idx;
    int cyc;
    bit done_seen;
    p = ref_seed(seed);
    for (int i = 0; i < int'(num); i++) begin
      q.push_back(p);
      p = ref_next(p);
    end
    first_pat = '0;
    last_pat  = '0;
    idx       = 0;
    done_seen = 1'b0;
    @(negedge i_clk);
    i_seed = seed;
    i_num_patterns = num;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_load", 64'(o_busy), 64'(1));
    chk("vld_load", 64'(o_vld), 64'(0));
    for (cyc = 0; cyc < 500 && !done_seen; cyc++) begin
      if (o_done) begin
        done_seen = 1'b1;
        chk("done_cnt", 64'(idx), 64'(num));
        chk("done_busy", 64'(o_busy), 64'(0));
        chk("done_vld", 64'(o_vld), 64'(0));
        if (ready_pct >= 100) chk("done_lat", 64'(cyc), 64'(int'(num) + 1));
      end else begin
        i_ready = ($urandom_range(99, 0) < 32'(ready_pct));
        if (o_vld) begin
          if (idx >= q.size()) begin
            chk("extra_vld", 64'(o_vld), 64'(0));
          end else begin
            chk("data", 64'(o_data), 64'(q[idx]));
            chk("first", 64'(o_first), 64'(idx == 0));
            chk("cnt", 64'(o_pattern_cnt), 64'(idx));
            chk("busy_run", 64'(o_busy), 64'(1));
            if (i_ready) begin
              if (idx == 0) first_pat = o_data;
              last_pat = o_data;
              idx++;
            end
          end
        end else if (cyc > 0) begin
          chk("vld_gap", 64'(o_vld), 64'(1));
        end
        @(negedge i_clk);
      end
    end
    if (!done_seen) chk("done_timeout", 64'(done_seen), 64'(1));
    i_ready = 1'b0;
    @(negedge i_clk);
    chk("done_pulse", 64'(o_done), 64'(0));
    chk("idle_cnt", 64'(o_pattern_cnt), 64'(num));
    chk("idle_data", 64'(o_data), 64'(p));
    ntx = idx;
  endtask

  initial begin
    logic [NB-1:0] f;
    logic [NB-1:0] l;
    logic [NB-1:0] s;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] p;
    int n;
    int got;

    n_pass = 0;
    n_total = 0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_seed = '0;
    i_num_patterns = '0;
    i_ready = 1'b0;

    tbl[0] = '{seed: 54'h0,              num: 16'd4, exp_first: 54'h0,              exp_last: 54'h7};
    tbl[1] = '{seed: {NB{1'b1}},         num: 16'd2, exp_first: 54'h0,              exp_last: 54'h1};
    tbl[2] = '{seed: 54'h1,              num: 16'd1, exp_first: 54'h1,              exp_last: 54'h1};
    tbl[3] = '{seed: 54'h0,              num: 16'd0, exp_first: 54'h0,              exp_last: 54'h0};
    tbl[4] = '{seed: 54'h3,              num: 16'd3, exp_first: 54'h3,              exp_last: 54'hF};
    tbl[5] = '{seed: 54'h20000000000000, num: 16'd2, exp_first: 54'h20000000000000, exp_last: 54'h0};
    tbl[6] = '{seed: 54'h10000,          num: 16'd3, exp_first: 54'h10000,          exp_last: 54'h40000};

    repeat (2) @(negedge i_clk);
    chk("rst_vld", 64'(o_vld), 64'(0));
    chk("rst_first", 64'(o_first), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_cnt", 64'(o_pattern_cnt), 64'(0));
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int i = 0; i < 7; i++) begin
      run_test(tbl[i].seed, tbl[i].num, 100, f, l, n);
      chk("tbl_ntx", 64'(n), 64'(tbl[i].num));
      if (tbl[i].num != 0) begin
        chk("tbl_first", 64'(f), 64'(tbl[i].exp_first));
        chk("tbl_last", 64'(l), 64'(tbl[i].exp_last));
      end
    end

    // Back-pressure on the second pattern
    @(negedge i_clk);
    i_seed = '0;
    i_num_patterns = 16'd3;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("stall_p0", 64'(o_data), 64'(0));
    chk("stall_first0", 64'(o_first), 64'(1));
    @(negedge i_clk);
    chk("stall_p1", 64'(o_data), 64'(1));
    chk("stall_first1", 64'(o_first), 64'(0));
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("stall_hold_data", 64'(o_data), 64'(1));
      chk("stall_hold_vld", 64'(o_vld), 64'(1));
      chk("stall_hold_cnt", 64'(o_pattern_cnt), 64'(1));
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("stall_p2", 64'(o_data), 64'(3));
    chk("stall_cnt2", 64'(o_pattern_cnt), 64'(2));
    @(negedge i_clk);
    chk("stall_done", 64'(o_done), 64'(1));
    chk("stall_cnt3", 64'(o_pattern_cnt), 64'(3));
    i_ready = 1'b0;
    @(negedge i_clk);

    // Abort after two transfers, with a stray start request held during the run
    s = 54'h2A5A5A5A5A5A5;
    exp_q.delete();
    p = ref_seed(s);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(p);
      p = ref_next(p);
    end
    @(negedge i_clk);
    i_seed = s;
    i_num_patterns = 16'd10;
    i_start = 1'b1;
    @(negedge i_clk);
    i_seed = 54'h123;
    i_num_patterns = 16'd1;
    i_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      @(negedge i_clk);
      if (o_vld) begin
        chk("abort_seq", 64'(o_data), 64'(exp_q[got]));
        got++;
      end
    end
    @(negedge i_clk);
    chk("abort_pre_cnt", 64'(o_pattern_cnt), 64'(2));
    chk("abort_pre_data", 64'(o_data), 64'(exp_q[2]));
    i_abort = 1'b1;
    i_start = 1'b0;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort_vld", 64'(o_vld), 64'(0));
    chk("abort_busy", 64'(o_busy), 64'(0));
    chk("abort_first", 64'(o_first), 64'(0));
    chk("abort_cnt", 64'(o_pattern_cnt), 64'(2));
    chk("abort_data", 64'(o_data), 64'(exp_q[2]));
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", 64'(o_done), 64'(0));
      chk("abort_idle_vld", 64'(o_vld), 64'(0));
      @(negedge i_clk);
    end
    i_ready = 1'b0;

    // Asynchronous reset in the middle of a run
    i_seed = 54'h5;
    i_num_patterns = 16'd8;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("mid_vld_pre", 64'(o_vld), 64'(1));
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(o_vld), 64'(0));
    chk("mid_rst_first", 64'(o_first), 64'(0));
    chk("mid_rst_busy", 64'(o_busy), 64'(0));
    chk("mid_rst_done", 64'(o_done), 64'(0));
    chk("mid_rst_data", 64'(o_data), 64'(0));
    chk("mid_rst_cnt", 64'(o_pattern_cnt), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("post_rst_vld", 64'(o_vld), 64'(0));
      chk("post_rst_busy", 64'(o_busy), 64'(0));
    end
    i_ready = 1'b0;

    // Randomized tests against the reference model
    for (int t = 0; t < 12; t++) begin
      s = NB'({$urandom, $urandom});
      if (t == 3) s = {NB{1'b1}};
      run_test(s, CB'($urandom_range(12, 0)), int'($urandom_range(100, 30)), f, l, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bist_prpg.md
BIST_PRPG -- requirements
Module: bist_prpg

Interface
REQ-001 SHALL have parameter NUM_BITS, default 54, pattern width; fixed at 54 by the tap set.
REQ-002 SHALL have parameter CNT_BITS, default 16, width of the pattern counter.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  start-of-test request, sampled in IDLE only.
REQ-006 SHALL have port i_abort  input  1  abort the test in progress.
REQ-007 SHALL have port i_seed  input  NUM_BITS  LFSR seed, captured on accepted i_start.
REQ-008 SHALL have port i_num_patterns  input  CNT_BITS  pattern count, captured on accepted i_start.
REQ-009 SHALL have port i_ready  input  1  downstream accepts o_data.
REQ-010 SHALL have port o_vld  output  1  o_data holds a valid pattern.
REQ-011 SHALL have port o_data  output  NUM_BITS  current pseudo-random pattern.
REQ-012 SHALL have port o_first  output  1  first pattern of a test; drives the signature compactor's load.
REQ-013 SHALL have port o_busy  output  1  high in LOAD or RUN.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse at normal test completion.
REQ-015 SHALL have port o_pattern_cnt  output  CNT_BITS  patterns accepted so far.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-017 SHALL, in IDLE with i_start=1, capture i_seed and i_num_patterns, clear the counter and go to LOAD.
REQ-018 SHALL, in LOAD, go to DONE if the captured count is 0, else to RUN.
REQ-019 SHALL, in RUN, assert o_vld=1 with o_data equal to the seed on the first RUN cycle (latency 2 cycles from i_start).
REQ-020 SHALL treat o_vld&&i_ready as a transfer: advance the LFSR and increment o_pattern_cnt.
REQ-021 SHALL hold o_data and o_vld stable while o_vld=1 and i_ready=0.
REQ-022 SHALL compute the LFSR step as next = {o_data[52:0], x}, where x = ((o_data[53] XNOR o_data[52]) XNOR o_data[17]) XNOR o_data[16].
REQ-023 SHALL replace an all-ones seed (the XNOR lockup state) with all-zeros at capture.
REQ-024 SHALL, on a transfer while o_pattern_cnt = count-1, deassert o_vld and go to DONE on the next cycle.
REQ-025 SHALL assert o_first with o_vld for the first pattern only, and hold it until that pattern is transferred.
REQ-026 SHALL, in DONE, pulse o_done for one cycle and return to IDLE.
REQ-027 SHALL ignore i_start in LOAD, RUN and DONE.
REQ-028 SHALL, on i_abort=1 in LOAD or RUN, go to IDLE next cycle with o_vld=0 and no o_done pulse; abort takes priority over a simultaneous transfer.
REQ-029 SHALL keep o_pattern_cnt and o_data unchanged in IDLE until the next accepted i_start.

Reset
REQ-030 SHALL, on i_rst_n=0, immediately force IDLE with o_vld=0, o_first=0, o_busy=0, o_done=0, o_data=0 and o_pattern_cnt=0, including in the middle of a test.
REQ-031 SHALL require a new i_start after reset release before any pattern is issued.

Structure
REQ-032 SHALL take the state enum, the tap positions (53, 52, 17, 16) and the default widths from shared package bist_pkg.
REQ-033 SHALL place the LFSR register with its seed-load and step logic in sub-module prpg_lfsr; the FSM, counter and handshake stay in bist_prpg.

Verification
REQ-034 SHALL cover: seed=0, num=4, i_ready=1 -> o_data 0x0, 0x1, 0x3, 0x7 on consecutive cycles, o_first on the first only, o_done one cycle after the last, o_pattern_cnt=4.
REQ-035 SHALL cover: seed=0, num=3, i_ready low for 3 cycles on pattern 2 -> o_data stays 0x1 with o_vld high throughout, and the sequence then continues 0x3.
REQ-036 SHALL cover: num=0 -> o_busy for 1 cycle, no o_vld, o_done pulse 2 cycles after i_start.
REQ-037 SHALL cover: seed all-ones -> first pattern 0x0.
REQ-038 SHALL cover: i_abort after 2 transfers -> IDLE next cycle, no o_done, o_pattern_cnt=2; i_start during RUN is ignored.
REQ-039 SHALL cover: i_rst_n low mid-RUN -> all outputs 0 without waiting for a clock edge.
